// File: rtl/sgf_seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : sgf_seq_multiplier_if
//  Description : Request/response bundle for the sequential significand
//                multiplier: start + operands in, busy/done/product out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sgf_seq_multiplier_if #(
    parameter int SW = 24
);
    logic            start;
    logic [SW-1:0]   A;
    logic [SW-1:0]   B;
    logic            busy;
    logic            done;
    logic [2*SW-1:0] P;

    // Requester side: issues start and operands, observes status and product
    modport master (
        output start, A, B,
        input  busy, done, P
    );

    // Multiplier side
    modport slave (
        input  start, A, B,
        output busy, done, P
    );
endinterface

`default_nettype wire

// File: rtl/sgf_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : sgf_seq_multiplier
//  Description : Iterative radix-2 shift-and-add multiplier for unsigned
//                significands (hidden bit included). One partial product per
//                clock, SW iterations, one-cycle done pulse with the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgf_seq_multiplier #(
    parameter int SW = 24
) (
    input  logic                clk,
    input  logic                rst,
    sgf_seq_multiplier_if.slave bus
);

    localparam int            CW       = $clog2(SW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   mcand_q, mcand_d;
    logic [SW-1:0]   mplr_q,  mplr_d;
    logic [SW:0]     acc_q,   acc_d;     // one extra bit holds the adder carry
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [2*SW-1:0] p_q,     p_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [SW:0]     w_sum;
    logic [2*SW:0]   w_shift;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: capture in IDLE, add-and-shift in RUN, pulse in DONE
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // The accumulator stays below 2^SW after every shift, so the sum
        // always fits in SW+1 bits and the shifted-out carry ends up zero.
        w_sum   = mplr_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
        w_shift = {w_sum, mplr_q} >> 1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.A;
                    mplr_d  = bus.B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = w_shift[2*SW:SW];
                mplr_d = w_shift[SW-1:0];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = w_shift[2*SW-1:0];
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.P    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_sgf_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sgf_seq_multiplier
//  Description : Self-checking bench for sgf_seq_multiplier (SW=24 and SW=53)
//                against plain integer multiplication.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sgf_seq_multiplier;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [47:0] last_p;   // product the SW=24 instance should currently hold

    sgf_seq_multiplier_if #(.SW(24)) bus24 ();
    sgf_seq_multiplier_if #(.SW(53)) bus53 ();

    sgf_seq_multiplier #(.SW(24)) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24)
    );

    sgf_seq_multiplier #(.SW(53)) dut53 (
        .clk (clk),
        .rst (rst),
        .bus (bus53)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on the SW=24 instance: latency, busy span, single done
    // pulse, product value and product hold while the operation runs.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] exp_p;
        int n;
        int busy_cycles;
        bit seen;
        exp_p = 48'(a) * 48'(b);
        bus24.start = 1'b1;
        bus24.A     = a;
        bus24.B     = b;
        step();
        bus24.start = 1'b0;
        bus24.A     = 24'($urandom);
        bus24.B     = 24'($urandom);
        n = 1;
        busy_cycles = 0;
        seen = 1'b0;
        while (n <= 60) begin
            if (bus24.busy === 1'b1) busy_cycles++;
            if (bus24.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (bus24.P !== last_p) begin
                failures++;
                $display("FAIL p_hold: P=%0h expected %0h (cycle %0d)", bus24.P, last_p, n);
            end
            // stray starts while busy must be ignored
            bus24.start = 1'($urandom_range(0, 1));
            bus24.A     = 24'($urandom);
            bus24.B     = 24'($urandom);
            step();
            n++;
        end
        bus24.start = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout: no done within 60 cycles for %0h*%0h", a, b);
        end
        checks++;
        if (n !== 25) begin
            failures++;
            $display("FAIL latency: done at cycle %0d expected 25", n);
        end
        checks++;
        if (busy_cycles !== 25) begin
            failures++;
            $display("FAIL busy_span: busy for %0d cycles expected 25", busy_cycles);
        end
        checks++;
        if (bus24.P !== exp_p) begin
            failures++;
            $display("FAIL product: %0h*%0h gave %0h expected %0h", a, b, bus24.P, exp_p);
        end
        last_p = exp_p;
        step();
        checks++;
        if (bus24.done !== 1'b0 || bus24.busy !== 1'b0) begin
            failures++;
            $display("FAIL after_done: done=%0b busy=%0b expected 0 0", bus24.done, bus24.busy);
        end
        checks++;
        if (bus24.P !== exp_p) begin
            failures++;
            $display("FAIL p_after: P=%0h expected %0h", bus24.P, exp_p);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus24.busy !== 1'b0 || bus24.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%0b done=%0b expected 0 0", bus24.busy, bus24.done);
        end
        checks++;
        if (bus24.P !== 48'h0) begin
            failures++;
            $display("FAIL reset_p: P=%0h expected 0", bus24.P);
        end
        checks++;
        if (bus53.P !== 106'h0 || bus53.busy !== 1'b0 || bus53.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_53: P=%0h busy=%0b done=%0b expected 0 0 0",
                     bus53.P, bus53.busy, bus53.done);
        end
    endtask

    task automatic test_directed();
        run_op(24'h800000, 24'h800000);
        run_op(24'hFFFFFF, 24'hFFFFFF);
        run_op(24'hC00000, 24'hA00000);
        run_op(24'h000000, 24'hABCDEF);
        run_op(24'hABCDEF, 24'h000000);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            run_op(24'($urandom), 24'($urandom));
        end
    endtask

    // start held high with fresh operands every cycle: only operands present
    // at the accepted edges (every 26 cycles) contribute to results.
    task automatic test_start_held();
        logic [23:0] ha [0:79];
        logic [23:0] hb [0:79];
        logic [47:0] exp_p;
        bit exp_done;
        for (int i = 0; i < 80; i++) begin
            ha[i] = 24'($urandom);
            hb[i] = 24'($urandom);
        end
        bus24.start = 1'b1;
        bus24.A     = ha[0];
        bus24.B     = hb[0];
        for (int c = 0; c < 78; c++) begin
            step();
            bus24.A = ha[c+1];
            bus24.B = hb[c+1];
            exp_done = (((c + 1) % 26) == 25);
            checks++;
            if (bus24.done !== exp_done) begin
                failures++;
                $display("FAIL held_done: cycle %0d done=%0b expected %0b", c + 1, bus24.done, exp_done);
            end
            if (exp_done) begin
                exp_p = 48'(ha[26 * ((c + 1) / 26)]) * 48'(hb[26 * ((c + 1) / 26)]);
                checks++;
                if (bus24.P !== exp_p) begin
                    failures++;
                    $display("FAIL held_product: cycle %0d P=%0h expected %0h", c + 1, bus24.P, exp_p);
                end
                last_p = exp_p;
            end
        end
        bus24.start = 1'b0;
        step();
        checks++;
        if (bus24.busy !== 1'b0) begin
            failures++;
            $display("FAIL held_idle: busy=%0b expected 0", bus24.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit any_done;
        bus24.start = 1'b1;
        bus24.A     = 24'($urandom);
        bus24.B     = 24'($urandom);
        step();
        bus24.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus24.busy !== 1'b0 || bus24.done !== 1'b0 || bus24.P !== 48'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%0b done=%0b P=%0h expected 0 0 0",
                     bus24.busy, bus24.done, bus24.P);
        end
        last_p = 48'h0;
        step();
        step();
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus24.done === 1'b1 || bus24.busy === 1'b1) any_done = 1'b1;
        end
        checks++;
        if (any_done) begin
            failures++;
            $display("FAIL abort: done or busy seen after reset abort, expected 0");
        end
        run_op(24'd3, 24'd5);
    endtask

    task automatic op53(input logic [52:0] a, input logic [52:0] b);
        logic [105:0] exp_p;
        int n;
        exp_p = 106'(a) * 106'(b);
        bus53.start = 1'b1;
        bus53.A     = a;
        bus53.B     = b;
        step();
        bus53.start = 1'b0;
        bus53.A     = '0;
        bus53.B     = '0;
        n = 1;
        while (n <= 100 && bus53.done !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (n !== 54) begin
            failures++;
            $display("FAIL latency_53: done at cycle %0d expected 54", n);
        end
        checks++;
        if (bus53.P !== exp_p) begin
            failures++;
            $display("FAIL product_53: P=%0h expected %0h", bus53.P, exp_p);
        end
        step();
    endtask

    task automatic test_sw53();
        logic [52:0] one;
        logic [52:0] ra;
        logic [52:0] rb;
        one = 53'd1;
        op53(one << 52, one << 52);
        ra = {21'($urandom), 32'($urandom)};
        rb = {21'($urandom), 32'($urandom)};
        op53(ra, rb);
    endtask

    initial begin
        rst = 1'b1;
        bus24.start = 1'b0;
        bus24.A = '0;
        bus24.B = '0;
        bus53.start = 1'b0;
        bus53.A = '0;
        bus53.B = '0;
        last_p = 48'h0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_directed();
        test_back_to_back();
        test_start_held();
        test_reset_mid_run();
        test_sw53();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
